// File: rtl/cis_skip_sequencer.sv
// cis_skip_sequencer
//   Gate pattern generator for the CIS readout path. When integration falls,
//   the block plays three programmable segments onto the gate drivers:
//   PRE once, SKIP num_skips times and POST once. Between sequences the
//   gates rest at idle_level.
//
// Ports
//   clk          system clock
//   reset        asynchronous reset, active low
//   integration  integration window; a high-to-low transition starts a sequence
//   abort        synchronous abort of a running sequence
//   num_skips    number of SKIP repetitions, captured when the sequence starts
//   pre_pattern  PRE segment; bit s*PRE_LEN+k is signal s at step k
//   skip_pattern SKIP segment, same layout
//   post_pattern POST segment, same layout
//   idle_level   gate levels while no sequence is running
//   signal       registered gate outputs
//   running      high while a sequence drives signal
//   skip_index   current SKIP repetition (0-based); held through POST
//   done         one-cycle pulse when a sequence completes normally
//   overrun      one-cycle pulse when a trigger arrives during a sequence
module cis_skip_sequencer #(
  parameter int NUM_SIGNALS = 8,
  parameter int PRE_LEN     = 10,
  parameter int SKIP_LEN    = 20,
  parameter int POST_LEN    = 10,
  parameter int SKIP_CW     = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            integration,
  input  logic                            abort,
  input  logic [SKIP_CW-1:0]              num_skips,
  input  logic [NUM_SIGNALS*PRE_LEN-1:0]  pre_pattern,
  input  logic [NUM_SIGNALS*SKIP_LEN-1:0] skip_pattern,
  input  logic [NUM_SIGNALS*POST_LEN-1:0] post_pattern,
  input  logic [NUM_SIGNALS-1:0]          idle_level,
  output logic [NUM_SIGNALS-1:0]          signal,
  output logic                            running,
  output logic [SKIP_CW-1:0]              skip_index,
  output logic                            done,
  output logic                            overrun
);

  localparam int MAX_LEN_PS = (PRE_LEN > SKIP_LEN) ? PRE_LEN : SKIP_LEN;
  localparam int MAX_LEN    = (MAX_LEN_PS > POST_LEN) ? MAX_LEN_PS : POST_LEN;
  localparam int KW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [KW-1:0] PRE_LAST  = KW'(PRE_LEN - 1);
  localparam logic [KW-1:0] SKIP_LAST = KW'(SKIP_LEN - 1);
  localparam logic [KW-1:0] POST_LAST = KW'(POST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_SKIP,
    ST_POST
  } state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [SKIP_CW-1:0]     r_q, r_d;
  logic [SKIP_CW-1:0]     nsk_q, nsk_d;
  logic [NUM_SIGNALS-1:0] signal_q, signal_d;
  logic                   running_q, running_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic                   integ_q, integ_d;
  logic                   fall;

  // One column of a segment: the value of every gate at step k.
  function automatic logic [NUM_SIGNALS-1:0] column(input state_t seg,
                                                    input logic [KW-1:0] k);
    logic [NUM_SIGNALS-1:0] col;
    col = '0;
    for (int s = 0; s < NUM_SIGNALS; s++) begin
      case (seg)
        ST_PRE:  col[s] = pre_pattern[s*PRE_LEN + int'(k)];
        ST_SKIP: col[s] = skip_pattern[s*SKIP_LEN + int'(k)];
        ST_POST: col[s] = post_pattern[s*POST_LEN + int'(k)];
        default: col[s] = 1'b0;
      endcase
    end
    return col;
  endfunction

  assign fall = integ_q & ~integration;

  // Next-state logic. k_q is the column currently on the outputs, so the
  // column chosen here for state_d/k_d is what appears after the edge.
  // Segments chain back-to-back; abort overrides everything except the
  // overrun pulse, which still reports a trigger seen while busy.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    r_d       = r_q;
    nsk_d     = nsk_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;
    integ_d   = integration;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          nsk_d   = num_skips;
          state_d = ST_PRE;
          k_d     = '0;
          r_d     = '0;
        end
      end
      ST_PRE: begin
        if (k_q == PRE_LAST) begin
          k_d     = '0;
          state_d = (nsk_q == '0) ? ST_POST : ST_SKIP;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_SKIP: begin
        if (k_q == SKIP_LAST) begin
          k_d = '0;
          if (r_q == nsk_q - 1'b1) begin
            state_d = ST_POST;
          end else begin
            r_d = r_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_POST: begin
        if (k_q == POST_LAST) begin
          state_d = ST_IDLE;
          k_d     = '0;
          r_d     = '0;
          done_d  = 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = '0;
        r_d     = '0;
      end
    endcase

    if (state_q != ST_IDLE) begin
      overrun_d = fall;
      if (abort) begin
        state_d = ST_IDLE;
        k_d     = '0;
        r_d     = '0;
        done_d  = 1'b0;
      end
    end

    running_d = (state_d != ST_IDLE);
    signal_d  = running_d ? column(state_d, k_d) : idle_level;
  end

  // State and output registers; reset clears every output straight away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      r_q       <= '0;
      nsk_q     <= '0;
      signal_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      integ_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      r_q       <= r_d;
      nsk_q     <= nsk_d;
      signal_q  <= signal_d;
      running_q <= running_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      integ_q   <= integ_d;
    end
  end

  assign signal     = signal_q;
  assign running    = running_q;
  assign skip_index = r_q;
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_cis_skip_sequencer.sv
// tb_cis_skip_sequencer
//   Self-checking bench for cis_skip_sequencer. A reference model expands each
//   triggered sequence into a queue of expected (gate column, skip index)
//   pairs and replays one entry per clock.
module tb_cis_skip_sequencer;

  localparam int NS   = 8;
  localparam int PRE  = 10;
  localparam int SKIP = 20;
  localparam int POST = 10;
  localparam int CW   = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              integration;
  logic              abort;
  logic [CW-1:0]     numSkips;
  logic [NS*PRE-1:0] prePat;
  logic [NS*SKIP-1:0] skipPat;
  logic [NS*POST-1:0] postPat;
  logic [NS-1:0]     idleLevel;
  logic [NS-1:0]     signalOut;
  logic              running;
  logic [CW-1:0]     skipIndex;
  logic              done;
  logic              overrun;

  cis_skip_sequencer #(
    .NUM_SIGNALS(NS), .PRE_LEN(PRE), .SKIP_LEN(SKIP), .POST_LEN(POST), .SKIP_CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .integration(integration), .abort(abort),
    .num_skips(numSkips), .pre_pattern(prePat), .skip_pattern(skipPat),
    .post_pattern(postPat), .idle_level(idleLevel), .signal(signalOut),
    .running(running), .skip_index(skipIndex), .done(done), .overrun(overrun)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0] sig;
    int            idx;
  } step_t;

  step_t         expQ[$];
  bit            mdlRunning;
  logic          mdlPrevInteg;
  logic [NS-1:0] expSignal;
  int            expIdx;
  logic          expDone;
  logic          expOverrun;

  int compared   = 0;
  int mismatched = 0;
  int runCount, doneCount, overrunCount;

  // Single comparison point: counts and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Column k of a segment (0=PRE, 1=SKIP, 2=POST) straight from the layout rule.
  function automatic logic [NS-1:0] colOf(input int seg, input int k);
    logic [NS-1:0] c;
    c = '0;
    for (int s = 0; s < NS; s++) begin
      if (seg == 0)      c[s] = prePat[s*PRE + k];
      else if (seg == 1) c[s] = skipPat[s*SKIP + k];
      else               c[s] = postPat[s*POST + k];
    end
    return c;
  endfunction

  // Expand a whole sequence into the per-cycle expected trace.
  task automatic buildSequence(input int nsk);
    step_t st;
    expQ.delete();
    for (int k = 0; k < PRE; k++) begin
      st.sig = colOf(0, k); st.idx = 0; expQ.push_back(st);
    end
    for (int r = 0; r < nsk; r++) begin
      for (int k = 0; k < SKIP; k++) begin
        st.sig = colOf(1, k); st.idx = r; expQ.push_back(st);
      end
    end
    for (int k = 0; k < POST; k++) begin
      st.sig = colOf(2, k); st.idx = (nsk == 0) ? 0 : nsk - 1; expQ.push_back(st);
    end
  endtask

  // Advance the reference model by one clock edge using the current inputs.
  task automatic modelEdge();
    logic  fall;
    step_t st;
    if (!reset) begin
      expQ.delete();
      mdlRunning   = 1'b0;
      mdlPrevInteg = 1'b0;
      expSignal    = '0;
      expIdx       = 0;
      expDone      = 1'b0;
      expOverrun   = 1'b0;
      return;
    end
    fall         = mdlPrevInteg && !integration;
    mdlPrevInteg = integration;
    expDone      = 1'b0;
    expOverrun   = 1'b0;
    if (mdlRunning) begin
      expOverrun = fall;
      if (abort) begin
        expQ.delete();
        mdlRunning = 1'b0;
      end else if (expQ.size() == 0) begin
        mdlRunning = 1'b0;
        expDone    = 1'b1;
      end
    end else if (fall) begin
      buildSequence(int'(numSkips));
      mdlRunning = 1'b1;
    end
    if (mdlRunning) begin
      st        = expQ.pop_front();
      expSignal = st.sig;
      expIdx    = st.idx;
    end else begin
      expSignal = idleLevel;
      expIdx    = 0;
    end
  endtask

  // One clock: model at the rising edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput("signal",     32'(signalOut), 32'(expSignal));
    checkOutput("running",    32'(running),   32'(mdlRunning));
    checkOutput("skip_index", 32'(skipIndex), 32'(expIdx));
    checkOutput("done",       32'(done),      32'(expDone));
    checkOutput("overrun",    32'(overrun),   32'(expOverrun));
    if (running) runCount++;
    if (done) doneCount++;
    if (overrun) overrunCount++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clearCounts();
    runCount = 0; doneCount = 0; overrunCount = 0;
  endtask

  // New random patterns plus the run settings, with integration raised.
  task automatic applyStimulus(input int nsk, input logic [NS-1:0] idle);
    for (int i = 0; i < NS*PRE; i++)  prePat[i]  = 1'($urandom);
    for (int i = 0; i < NS*SKIP; i++) skipPat[i] = 1'($urandom);
    for (int i = 0; i < NS*POST; i++) postPat[i] = 1'($urandom);
    numSkips    = CW'(nsk);
    idleLevel   = idle;
    integration = 1'b1;
    ticks(2);
  endtask

  initial begin
    reset = 1'b0; integration = 1'b1; abort = 1'b0;
    numSkips = '0; idleLevel = '0; prePat = '0; skipPat = '0; postPat = '0;
    clearCounts();
    ticks(3);
    reset = 1'b1;

    // Full sequence with two SKIP repetitions after a long integration.
    applyStimulus(2, 8'h00);
    ticks(48);
    clearCounts();
    integration = 1'b0;
    ticks(70);
    checkOutput("s1_len",  32'(runCount),  32'(PRE + 2*SKIP + POST));
    checkOutput("s1_done", 32'(doneCount), 32'd1);

    // No SKIP repetitions: PRE runs straight into POST.
    applyStimulus(0, 8'h5A);
    clearCounts();
    integration = 1'b0;
    ticks(25);
    checkOutput("s2_len", 32'(runCount), 32'(PRE + POST));

    // Second trigger 15 cycles in is reported but ignored.
    applyStimulus(1, 8'h0F);
    clearCounts();
    integration = 1'b0;
    ticks(5);
    integration = 1'b1;
    ticks(9);
    integration = 1'b0;
    ticks(45);
    checkOutput("s3_len",     32'(runCount),     32'(PRE + SKIP + POST));
    checkOutput("s3_overrun", 32'(overrunCount), 32'd1);
    checkOutput("s3_done",    32'(doneCount),    32'd1);

    // Abort mid-run, then a clean restart.
    applyStimulus(3, 8'hA5);
    clearCounts();
    integration = 1'b0;
    ticks(24);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ticks(5);
    checkOutput("s4_signal_idle", 32'(signalOut), 32'h0A5);
    checkOutput("s4_no_done",     32'(doneCount), 32'd0);
    integration = 1'b1;
    ticks(2);
    integration = 1'b0;
    ticks(95);
    checkOutput("s4_restart_done", 32'(doneCount), 32'd1);

    // Asynchronous reset in the second SKIP repetition.
    applyStimulus(2, 8'h3C);
    integration = 1'b0;
    ticks(35);
    checkOutput("s5_pre_reset_idx", 32'(skipIndex), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("s5_async_signal",  32'(signalOut), 32'd0);
    checkOutput("s5_async_running", 32'(running),   32'd0);
    checkOutput("s5_async_idx",     32'(skipIndex), 32'd0);
    tick();
    reset = 1'b1;
    clearCounts();
    ticks(10);
    checkOutput("s5_no_retrigger", 32'(runCount), 32'd0);
    integration = 1'b1;
    ticks(2);
    integration = 1'b0;
    ticks(65);

    // num_skips changes during PRE are ignored.
    applyStimulus(2, 8'hC3);
    clearCounts();
    integration = 1'b0;
    ticks(4);
    numSkips = CW'(5);
    ticks(70);
    checkOutput("s6_len", 32'(runCount), 32'(PRE + 2*SKIP + POST));

    // Random runs with stray triggers and occasional aborts.
    for (int it = 0; it < 8; it++) begin
      applyStimulus(int'($urandom_range(0, 3)), NS'($urandom));
      integration = 1'b0;
      for (int c = 0; c < 100; c++) begin
        abort = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 9) == 0) integration = ~integration;
        tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      integration = 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cis_skip_sequencer.md
Name: cis_skip_sequencer

Overview:
Next-generation CIS clock/gate pattern generator. It has three programmable pattern segments (PRE, SKIP, POST), and the SKIP segment repeats a run-time count of times, so one readout is no longer a fixed-length pattern. A falling edge on integration triggers the sequence. Sits between the readout controller and the CIS gate drivers (PDrst, TG1, TG2, SG, OG, FG_RST, DG, row select).

Parameters:
NUM_SIGNALS, 8, number of output gate signals
PRE_LEN, 10, clock ticks in PRE segment (charge transfer PD->SG), >=1
SKIP_LEN, 20, clock ticks in one skipping sample, >=1
POST_LEN, 10, clock ticks in POST segment, >=1
SKIP_CW, 10, width of skip count (max repeats 2^SKIP_CW-1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
integration  in  1  integration window; falling edge triggers a sequence
abort  in  1  synchronous abort request
num_skips  in  SKIP_CW  SKIP repeat count, latched at trigger
pre_pattern  in  NUM_SIGNALS*PRE_LEN  bit s*PRE_LEN+k = signal s at PRE step k
skip_pattern  in  NUM_SIGNALS*SKIP_LEN  same layout for SKIP
post_pattern  in  NUM_SIGNALS*POST_LEN  same layout for POST
idle_level  in  NUM_SIGNALS  signal value while not running
signal  out  NUM_SIGNALS  registered gate outputs
running  out  1  high while a sequence drives signal
skip_index  out  SKIP_CW  current SKIP repetition (0-based)
done  out  1  1-cycle pulse, sequence completed normally
overrun  out  1  1-cycle pulse, trigger arrived while running

Behaviour:
- Reset (async, reset=0): state IDLE, signal=0, running=0, skip_index=0, done=0, overrun=0, integ_d=0. On release, signal takes idle_level at the first clock edge.
- Trigger: integ_d registers integration every edge. fall = integ_d & ~integration, evaluated at edge T. Only a high-to-low transition counts, so integration held low does not retrigger.
- States: IDLE, PRE, SKIP, POST. Step counter k, repeat counter r.
- IDLE, fall at edge T:
  - latch num_skips into nsk
  - signal <= pre column 0, k=1, running <= 1, state PRE
  - First pattern column is visible in the cycle after edge T.
- Each edge in PRE/SKIP/POST: signal <= column k of the current segment. At the segment's last column, move to the next segment's column 0 on the following edge. There are no gap cycles between segments.
- Segment order:
  - PRE (PRE_LEN cycles), then SKIP nsk times, then POST (POST_LEN cycles).
  - nsk=0 skips the SKIP state entirely: PRE last column is followed directly by POST column 0.
  - skip_index = r during SKIP; it holds the last r during POST; it is 0 in IDLE and PRE.
- End: the edge after the POST last column drives signal <= idle_level, running <= 0, done <= 1 for one cycle, state IDLE.
- Total running cycles = PRE_LEN + nsk*SKIP_LEN + POST_LEN.
- A trigger coinciding with the done edge is ignored, because the state is not yet IDLE.
- abort=1 at any edge while running: signal <= idle_level, running <= 0, state IDLE, done stays 0. In IDLE, abort has no effect.
- fall while running: sequence continues unaffected; overrun <= 1 for one cycle. abort has priority over overrun in the same cycle, and overrun is still pulsed.
- num_skips and the pattern inputs may change mid-sequence:
  - num_skips changes are ignored (nsk is latched at trigger).
  - Pattern inputs are sampled live and must be held stable by the user.
- A reset assertion mid-sequence returns all outputs to reset values immediately.
- Counters k and r are sized clog2 of the segment max and SKIP_CW respectively. No wrap occurs for legal parameters.

Test Plan:
- Defaults, num_skips=2, integration 1 for 50 clks then 0: running high for exactly 10+40+10=60 cycles. signal matches pre cols 0..9, then skip cols 0..19 twice with skip_index 0 then 1, then post cols 0..9. done pulses once, signal returns to idle_level=8'h00.
- num_skips=0: running for 20 cycles. Post col 0 follows pre col 9 directly, skip_index stays 0.
- Second integration falling edge 15 cycles into a num_skips=1 sequence: overrun pulses one cycle, sequence length still 40, no second sequence starts.
- abort=1 at cycle 25 of a num_skips=3 run: next cycle signal=idle_level=8'hA5, running=0, done never asserts. A following trigger starts cleanly from pre col 0.
- reset driven 0 mid-SKIP (r=1): signal=0, running=0, skip_index=0 without waiting for a clock edge. After release, integration held low causes no trigger until it is raised and lowered again.
- num_skips changed from 2 to 5 during PRE: sequence still runs exactly 2 SKIP repetitions.
